// File: rtl/pbch_re_demux.sv
// PBCH RE demultiplexer: decodes the compacted SSB address stream, pairs each accepted
// address with its delayed RE memory read data and splits the REs into DMRS and data streams.
module pbch_re_demux #(
    parameter int IQ_W   = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        nu,
    input  logic [9:0]        addr_in,
    input  logic              addr_vld,
    input  logic              addr_done,
    input  logic [2*IQ_W-1:0] rd_data,
    output logic [2*IQ_W-1:0] dmrs_data,
    output logic [7:0]        dmrs_idx,
    output logic              dmrs_vld,
    output logic [2*IQ_W-1:0] data_out,
    output logic [8:0]        data_idx,
    output logic              data_vld,
    output logic              frame_done,
    output logic              cnt_err,
    output logic              addr_err
);
    localparam int         DW         = $clog2(RD_LAT + 1);
    localparam logic [7:0] DMRS_TOTAL = 8'd144;
    localparam logic [8:0] DATA_TOTAL = 9'd432;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [1:0]        nu_q, nu_d;
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0] pipe_dmrs_q, pipe_dmrs_d;
    logic [7:0]        dmrs_cnt_q, dmrs_cnt_d;
    logic [8:0]        data_cnt_q, data_cnt_d;
    logic [2*IQ_W-1:0] dmrs_data_q, dmrs_data_d;
    logic [7:0]        dmrs_idx_q, dmrs_idx_d;
    logic              dmrs_vld_q, dmrs_vld_d;
    logic [2*IQ_W-1:0] data_out_q, data_out_d;
    logic [8:0]        data_idx_q, data_idx_d;
    logic              data_vld_q, data_vld_d;
    logic              cnt_err_q, cnt_err_d;
    logic              addr_err_q, addr_err_d;

    logic [7:0] k;
    logic       addr_legal;
    logic       is_dmrs;
    logic       accept;
    logic       tap_vld;
    logic       tap_dmrs;
    logic       dmrs_full;
    logic       data_full;
    logic       dmrs_fire;
    logic       data_fire;
    logic       beat_dropped;

    // Symbol 1 only carries the two 48-subcarrier flanks around the SSS, hence the split range.
    always_comb begin
        k = 8'd0;
        if (addr_in < 10'd240) begin
            k = addr_in[7:0];
        end else if (addr_in < 10'd288) begin
            k = 8'(addr_in - 10'd240);
        end else if (addr_in < 10'd336) begin
            k = 8'(addr_in - 10'd96);
        end else begin
            k = 8'(addr_in - 10'd336);
        end
    end

    assign addr_legal = (addr_in < 10'd576);
    assign is_dmrs    = ((k & 8'h03) == {6'd0, nu_q});
    assign accept     = (state_q == RUN) && addr_vld && !start && addr_legal;

    assign tap_vld      = pipe_vld_q[RD_LAT-1] && !start;
    assign tap_dmrs     = pipe_dmrs_q[RD_LAT-1];
    assign dmrs_full    = (dmrs_cnt_q == DMRS_TOTAL);
    assign data_full    = (data_cnt_q == DATA_TOTAL);
    assign dmrs_fire    = tap_vld && tap_dmrs && !dmrs_full;
    assign data_fire    = tap_vld && !tap_dmrs && !data_full;
    assign beat_dropped = tap_vld && ((tap_dmrs && dmrs_full) || (!tap_dmrs && data_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            nu_q        <= 2'd0;
            pipe_vld_q  <= '0;
            pipe_dmrs_q <= '0;
            dmrs_cnt_q  <= 8'd0;
            data_cnt_q  <= 9'd0;
            dmrs_data_q <= '0;
            dmrs_idx_q  <= 8'd0;
            dmrs_vld_q  <= 1'b0;
            data_out_q  <= '0;
            data_idx_q  <= 9'd0;
            data_vld_q  <= 1'b0;
            cnt_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            nu_q        <= nu_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_dmrs_q <= pipe_dmrs_d;
            dmrs_cnt_q  <= dmrs_cnt_d;
            data_cnt_q  <= data_cnt_d;
            dmrs_data_q <= dmrs_data_d;
            dmrs_idx_q  <= dmrs_idx_d;
            dmrs_vld_q  <= dmrs_vld_d;
            data_out_q  <= data_out_d;
            data_idx_q  <= data_idx_d;
            data_vld_q  <= data_vld_d;
            cnt_err_q   <= cnt_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // A start in any state re-arms the frame, so it always lands in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (start)          state_d = RUN;
                else if (addr_done) state_d = DRAIN;
            end
            DRAIN: begin
                if (start)                    state_d = RUN;
                else if (drain_cnt_q == '0)   state_d = DONE;
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nu_d        = nu_q;
        drain_cnt_d = drain_cnt_q;
        pipe_vld_d  = '0;
        pipe_dmrs_d = '0;
        dmrs_cnt_d  = dmrs_cnt_q;
        data_cnt_d  = data_cnt_q;
        dmrs_data_d = dmrs_data_q;
        dmrs_idx_d  = dmrs_idx_q;
        dmrs_vld_d  = dmrs_fire;
        data_out_d  = data_out_q;
        data_idx_d  = data_idx_q;
        data_vld_d  = data_fire;
        cnt_err_d   = cnt_err_q;
        addr_err_d  = addr_err_q;

        if (start) begin
            nu_d = nu;
        end

        if ((state_q == RUN) && addr_done && !start) begin
            drain_cnt_d = DW'(RD_LAT);
        end else if ((state_q == DRAIN) && (drain_cnt_q != '0)) begin
            drain_cnt_d = drain_cnt_q - DW'(1);
        end

        pipe_vld_d[0]  = accept;
        pipe_dmrs_d[0] = is_dmrs;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_dmrs_d[i] = pipe_dmrs_q[i-1];
        end
        if (start) begin
            pipe_vld_d = '0;
        end

        // The index reported with a beat is the count before that beat is added.
        if (dmrs_fire) begin
            dmrs_data_d = rd_data;
            dmrs_idx_d  = dmrs_cnt_q;
        end
        if (data_fire) begin
            data_out_d = rd_data;
            data_idx_d = data_cnt_q;
        end

        if (start) begin
            dmrs_cnt_d = 8'd0;
            data_cnt_d = 9'd0;
        end else begin
            if (dmrs_fire) dmrs_cnt_d = dmrs_cnt_q + 8'd1;
            if (data_fire) data_cnt_d = data_cnt_q + 9'd1;
        end

        if (start) begin
            cnt_err_d  = 1'b0;
            addr_err_d = 1'b0;
        end else begin
            if ((state_q == RUN) && addr_vld && !addr_legal) begin
                addr_err_d = 1'b1;
            end
            if (beat_dropped) begin
                cnt_err_d = 1'b1;
            end
            if ((state_q == DONE) && ((dmrs_cnt_q != DMRS_TOTAL) || (data_cnt_q != DATA_TOTAL))) begin
                cnt_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        frame_done = (state_q == DONE);
        dmrs_data  = dmrs_data_q;
        dmrs_idx   = dmrs_idx_q;
        dmrs_vld   = dmrs_vld_q;
        data_out   = data_out_q;
        data_idx   = data_idx_q;
        data_vld   = data_vld_q;
        cnt_err    = cnt_err_q;
        addr_err   = addr_err_q;
    end

endmodule

// File: tb/tb_pbch_re_demux.sv
// Bench for pbch_re_demux: randomized SSB address streams scored against a cycle-indexed
// reference built from the subcarrier map, plus directed reset/error/restart scenarios.
module tb_pbch_re_demux;
    localparam int IQ_W   = 16;
    localparam int RD_LAT = 2;
    localparam int MAXC   = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        nu;
    logic [9:0]        addr_in;
    logic              addr_vld;
    logic              addr_done;
    logic [2*IQ_W-1:0] rd_data;
    logic [2*IQ_W-1:0] dmrs_data;
    logic [7:0]        dmrs_idx;
    logic              dmrs_vld;
    logic [2*IQ_W-1:0] data_out;
    logic [8:0]        data_idx;
    logic              data_vld;
    logic              frame_done;
    logic              cnt_err;
    logic              addr_err;

    always #5 clk = ~clk;

    pbch_re_demux #(.IQ_W(IQ_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nu         (nu),
        .addr_in    (addr_in),
        .addr_vld   (addr_vld),
        .addr_done  (addr_done),
        .rd_data    (rd_data),
        .dmrs_data  (dmrs_data),
        .dmrs_idx   (dmrs_idx),
        .dmrs_vld   (dmrs_vld),
        .data_out   (data_out),
        .data_idx   (data_idx),
        .data_vld   (data_vld),
        .frame_done (frame_done),
        .cnt_err    (cnt_err),
        .addr_err   (addr_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [31:0] mem [576];
    bit          hist_vld  [MAXC];
    int          hist_addr [MAXC];
    bit          exp_dv [MAXC];
    bit          exp_tv [MAXC];
    bit          exp_fd [MAXC];
    logic [31:0] exp_dd [MAXC];
    logic [31:0] exp_td [MAXC];
    int          exp_di [MAXC];
    int          exp_ti [MAXC];

    int m_nu;
    int m_dcnt;
    int m_tcnt;
    bit m_armed;
    bit m_over;
    bit m_aerr;
    int frame_q[$];
    int t_mark;

    function automatic bit ref_is_dmrs(int a, int n);
        int k;
        if (a < 240)      k = a;
        else if (a < 288) k = a - 240;
        else if (a < 336) k = a - 96;
        else              k = a - 336;
        return (k % 4) == n;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic checkOutput();
        checkVal("dmrs_vld", 32'(dmrs_vld), 32'(exp_dv[cyc]));
        checkVal("data_vld", 32'(data_vld), 32'(exp_tv[cyc]));
        checkVal("frame_done", 32'(frame_done), 32'(exp_fd[cyc]));
        checkVal("addr_err", 32'(addr_err), 32'(m_aerr));
        if (exp_dv[cyc]) begin
            checkVal("dmrs_data", dmrs_data, exp_dd[cyc]);
            checkVal("dmrs_idx", 32'(dmrs_idx), 32'(exp_di[cyc]));
        end
        if (exp_tv[cyc]) begin
            checkVal("data_out", data_out, exp_td[cyc]);
            checkVal("data_idx", 32'(data_idx), 32'(exp_ti[cyc]));
        end
    endtask

    task automatic applyStimulus(input bit st, input bit av, input int a, input bit ad,
                                 input bit rs, input int nv);
        int oc;
        if (cyc + RD_LAT + 3 >= MAXC) begin
            miscompares++;
            $display("[TB] FAIL cycle_budget observed=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        start     = st;
        addr_vld  = av;
        addr_in   = 10'(a);
        addr_done = ad;
        rst       = rs;
        nu        = st ? 2'(nv) : 2'($urandom);
        if (cyc >= RD_LAT && hist_vld[cyc-RD_LAT]) rd_data = mem[hist_addr[cyc-RD_LAT]];
        else                                       rd_data = 32'($urandom);
        hist_vld[cyc]  = av && (a < 576);
        hist_addr[cyc] = a;

        oc = cyc + RD_LAT + 1;
        if (rs || st) begin
            for (int c = cyc + 1; c <= cyc + RD_LAT + 2; c++) begin
                exp_dv[c] = 1'b0;
                exp_tv[c] = 1'b0;
                exp_fd[c] = 1'b0;
            end
            m_aerr  = 1'b0;
            m_over  = 1'b0;
            m_dcnt  = 0;
            m_tcnt  = 0;
            m_armed = !rs;
            if (!rs) m_nu = nv;
        end else if (m_armed) begin
            if (av && a >= 576) begin
                m_aerr = 1'b1;
            end else if (av) begin
                if (ref_is_dmrs(a, m_nu)) begin
                    if (m_dcnt < 144) begin
                        exp_dv[oc] = 1'b1;
                        exp_dd[oc] = mem[a];
                        exp_di[oc] = m_dcnt;
                        m_dcnt++;
                    end else begin
                        m_over = 1'b1;
                    end
                end else begin
                    if (m_tcnt < 432) begin
                        exp_tv[oc] = 1'b1;
                        exp_td[oc] = mem[a];
                        exp_ti[oc] = m_tcnt;
                        m_tcnt++;
                    end else begin
                        m_over = 1'b1;
                    end
                end
            end
            if (ad) begin
                exp_fd[cyc + RD_LAT + 2] = 1'b1;
                m_armed = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, int'($urandom_range(1023, 0)), 1'b0, 1'b0, 0);
    endtask

    task automatic buildStd();
        frame_q.delete();
        for (int k = 0; k < 240; k++) begin
            frame_q.push_back(k);
            if (k < 48)        frame_q.push_back(k + 240);
            else if (k >= 192) frame_q.push_back(k + 96);
            frame_q.push_back(k + 336);
        end
    endtask

    task automatic shuffleFrame();
        int j;
        int tmp;
        for (int i = frame_q.size() - 1; i > 0; i--) begin
            j          = int'($urandom_range(i, 0));
            tmp        = frame_q[i];
            frame_q[i] = frame_q[j];
            frame_q[j] = tmp;
        end
    endtask

    task automatic sendFrame(input int count);
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(3, 0) == 0) idle(1);
            applyStimulus(1'b0, 1'b1, frame_q[i], (i == count - 1), 1'b0, 0);
        end
    endtask

    task automatic checkCntErr(input string tag);
        checkVal(tag, 32'(cnt_err), 32'(m_over || (m_dcnt != 144) || (m_tcnt != 432)));
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_dmrs_data"}, dmrs_data, 32'd0);
        checkVal({tag, "_dmrs_idx"}, 32'(dmrs_idx), 32'd0);
        checkVal({tag, "_data_out"}, data_out, 32'd0);
        checkVal({tag, "_data_idx"}, 32'(data_idx), 32'd0);
        checkVal({tag, "_cnt_err"}, 32'(cnt_err), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 576; i++) mem[i] = 32'($urandom);

        // Reset, then stray addresses and addr_done while idle must be ignored.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
        checkAllZero("reset");
        applyStimulus(1'b0, 1'b1, 5, 1'b1, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 600, 1'b0, 1'b0, 0);
        idle(4);

        // First-beat latency: DMRS addr 0 then data addr 1 with nu=0.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        t_mark = cyc;
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0, 0);
        idle(1);
        checkVal("lat_dmrs_cycle", 32'(cyc - t_mark), 32'(RD_LAT + 1));
        checkVal("lat_dmrs_vld", 32'(dmrs_vld), 32'd1);
        checkVal("lat_dmrs_data", dmrs_data, mem[0]);
        idle(1);
        checkVal("lat_data_vld", 32'(data_vld), 32'd1);
        checkVal("lat_data_data", data_out, mem[1]);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
        idle(RD_LAT + 3);
        checkCntErr("lat_cnt_err");

        // Standard k-major frame, nu=0.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        checkVal("start_clears_cnt_err", 32'(cnt_err), 32'd0);
        buildStd();
        sendFrame(576);
        idle(RD_LAT + 3);
        checkCntErr("std_cnt_err");
        checkVal("std_last_dmrs_idx", 32'(dmrs_idx), 32'd143);
        checkVal("std_last_data_idx", 32'(data_idx), 32'd431);

        // nu=2 directed decode, an illegal address, then a short frame of 100 addresses.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 2);
        applyStimulus(1'b0, 1'b1, 290, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 241, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 575, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 600, 1'b0, 1'b0, 0);
        checkVal("bad_addr_err", 32'(addr_err), 32'd1);
        buildStd();
        shuffleFrame();
        sendFrame(97);
        idle(RD_LAT + 3);
        checkCntErr("short_cnt_err");
        checkVal("short_dmrs_count", 32'(m_dcnt + m_tcnt), 32'd100);

        // Overflow: 145 DMRS beats; the last one is dropped.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        checkVal("restart_clears_addr_err", 32'(addr_err), 32'd0);
        for (int i = 0; i < 145; i++) applyStimulus(1'b0, 1'b1, 4 * int'($urandom_range(59, 0)), (i == 144), 1'b0, 0);
        idle(RD_LAT + 3);
        checkCntErr("ovf_cnt_err");

        // Restart mid-frame flushes in-flight beats and restarts the indices.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        buildStd();
        shuffleFrame();
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, frame_q[i], 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 2);
        shuffleFrame();
        sendFrame(12);
        idle(RD_LAT + 3);
        checkCntErr("restart_cnt_err");

        // Reset (with a coincident start) 50 beats into a frame, then a clean shuffled frame.
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 1);
        shuffleFrame();
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, frame_q[i], 1'b0, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, frame_q[50], 1'b0, 1'b1, 2);
        checkAllZero("midrst");
        applyStimulus(1'b0, 1'b1, 700, 1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b1, 3, 1'b1, 1'b0, 0);
        idle(RD_LAT + 3);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 3);
        shuffleFrame();
        sendFrame(576);
        idle(RD_LAT + 3);
        checkCntErr("post_rst_cnt_err");
        checkVal("post_rst_last_dmrs_idx", 32'(dmrs_idx), 32'd143);
        checkVal("post_rst_last_data_idx", 32'(data_idx), 32'd431);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
